// File: rtl/rotor_step_ctrl.sv
// Keypress sequencer for the rotor chain: steps left/middle/right positions with
// notch and double-step rules, waits out the datapath latency, returns the result.
module rotor_step_ctrl #(
    parameter int NOTCH_R = 21,
    parameter int NOTCH_M = 4,
    parameter int DP_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_load,
    input  logic [5:0] cfg_pos_l,
    input  logic [5:0] cfg_pos_m,
    input  logic [5:0] cfg_pos_r,
    output logic       cfg_err,
    input  logic       key_valid,
    input  logic [5:0] key_code,
    output logic       key_ready,
    output logic       key_err,
    output logic [5:0] pos_l,
    output logic [5:0] pos_m,
    output logic [5:0] pos_r,
    output logic [5:0] dp_char,
    input  logic [5:0] dp_result,
    output logic       out_valid,
    output logic [5:0] out_char,
    input  logic       out_ready,
    output logic       busy
);

    localparam int              CNT_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DP_LAT - 1);
    localparam logic [5:0]      NOTCH_R6 = 6'(NOTCH_R);
    localparam logic [5:0]      NOTCH_M6 = 6'(NOTCH_M);
    localparam logic [5:0]      MAX_POS  = 6'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic key_fire;
    logic key_drop;
    logic cfg_fire;
    logic cfg_bad;
    logic cnt_done;
    logic out_fire;

    logic       step_m;
    logic       step_l;
    logic [5:0] next_l;
    logic [5:0] next_m;
    logic [5:0] next_r;

    function automatic logic [5:0] inc26(input logic [5:0] p);
        return (p >= MAX_POS) ? 6'd0 : p + 6'd1;
    endfunction

    function automatic logic [5:0] clamp26(input logic [5:0] p);
        return (p > MAX_POS) ? 6'd0 : p;
    endfunction

    assign key_ready = (state_q == ST_IDLE) && !cfg_load;
    assign busy      = (state_q != ST_IDLE);

    // Step decisions use the pre-step positions; a middle rotor on its notch steps itself.
    assign step_m = (pos_r == NOTCH_R6) || (pos_m == NOTCH_M6);
    assign step_l = (pos_m == NOTCH_M6);
    assign next_r = inc26(pos_r);
    assign next_m = step_m ? inc26(pos_m) : pos_m;
    assign next_l = step_l ? inc26(pos_l) : pos_l;

    assign cfg_bad = (cfg_pos_l > MAX_POS) || (cfg_pos_m > MAX_POS) || (cfg_pos_r > MAX_POS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cfg_load takes priority over a key in IDLE because key_ready is masked by it.
    always_comb begin
        state_d  = state_q;
        key_fire = 1'b0;
        key_drop = 1'b0;
        cfg_fire = 1'b0;
        cnt_done = 1'b0;
        out_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    cfg_fire = 1'b1;
                end else if (key_valid) begin
                    if (key_code <= MAX_POS) begin
                        key_fire = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        key_drop = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    cnt_done = 1'b1;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_l     <= 6'd0;
            pos_m     <= 6'd0;
            pos_r     <= 6'd0;
            dp_char   <= 6'd0;
            out_char  <= 6'd0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            key_err   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cfg_err <= cfg_load && (busy || cfg_bad);
            key_err <= key_drop;
            if (cfg_fire) begin
                pos_l <= clamp26(cfg_pos_l);
                pos_m <= clamp26(cfg_pos_m);
                pos_r <= clamp26(cfg_pos_r);
            end else if (key_fire) begin
                pos_l   <= next_l;
                pos_m   <= next_m;
                pos_r   <= next_r;
                dp_char <= key_code;
                cnt_q   <= CNT_INIT;
            end
            if (state_q == ST_WAIT && !cnt_done) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (cnt_done) begin
                out_char  <= dp_result;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
